// File: rtl/cpsr_flag_unit.sv
// NZCV flag register with condition-field evaluation.
// Flags update only when the retiring instruction passes its own condition.
module cpsr_flag_unit #(
   parameter logic [3:0] RESET_FLAGS     = 4'b0000,
   parameter int         CMP_ALWAYS_SETS = 1
) (
   input  logic       CLK,
   input  logic       nReset,
   input  logic       En,
   input  logic [3:0] CondIn,
   input  logic [3:0] OpCode,
   input  logic       SetFlags,
   input  logic       NFlagIn,
   input  logic       ZFlagIn,
   input  logic       CFlagIn,
   input  logic       VFlagIn,
   input  logic       ShifterCarry,
   input  logic       MsrWrite,
   input  logic [3:0] MsrData,
   output logic [3:0] Flags,
   output logic       CarryIn,
   output logic       CondPass
);

   logic       n_f;
   logic       z_f;
   logic       c_f;
   logic       v_f;
   logic       commit;
   logic       arith;
   logic       update;
   logic [3:0] next_flags;

   assign {n_f, z_f, c_f, v_f} = Flags;
   assign CarryIn = c_f;

   always_comb begin
      CondPass = 1'b1;
      unique case (CondIn)
         4'b0000: CondPass = z_f;
         4'b0001: CondPass = ~z_f;
         4'b0010: CondPass = c_f;
         4'b0011: CondPass = ~c_f;
         4'b0100: CondPass = n_f;
         4'b0101: CondPass = ~n_f;
         4'b0110: CondPass = v_f;
         4'b0111: CondPass = ~v_f;
         4'b1000: CondPass = c_f & ~z_f;
         4'b1001: CondPass = ~c_f | z_f;
         4'b1010: CondPass = (n_f == v_f);
         4'b1011: CondPass = (n_f != v_f);
         4'b1100: CondPass = ~z_f & (n_f == v_f);
         4'b1101: CondPass = z_f | (n_f != v_f);
         4'b1110: CondPass = 1'b1;
         4'b1111: CondPass = 1'b1;
      endcase
   end

   always_comb begin
      arith = 1'b0;
      case (OpCode)
         4'b0010, 4'b0011, 4'b0100, 4'b0101,
         4'b0110, 4'b0111, 4'b1010, 4'b1011: arith = 1'b1;
         default:                            arith = 1'b0;
      endcase
   end

   // Compare-class opcodes exist only to set flags, so S may be implied.
   assign update = SetFlags |
                   ((CMP_ALWAYS_SETS != 0) && (OpCode[3:2] == 2'b10));

   assign commit = En & CondPass;

   assign next_flags = arith ?
      {NFlagIn, ZFlagIn, CFlagIn, VFlagIn} :
      {NFlagIn, ZFlagIn, ShifterCarry, v_f};

   always_ff @(posedge CLK) begin
      if (!nReset) begin
         Flags <= RESET_FLAGS;
      end else if (commit) begin
         if (MsrWrite) begin
            Flags <= MsrData;
         end else if (update) begin
            Flags <= next_flags;
         end
      end
   end

endmodule

// File: tb/tb_cpsr_flag_unit.sv
// Directed self-checking bench for cpsr_flag_unit.
module tb_cpsr_flag_unit;

   logic       CLK = 1'b0;
   logic       nReset;
   logic       En;
   logic [3:0] CondIn;
   logic [3:0] OpCode;
   logic       SetFlags;
   logic       NFlagIn;
   logic       ZFlagIn;
   logic       CFlagIn;
   logic       VFlagIn;
   logic       ShifterCarry;
   logic       MsrWrite;
   logic [3:0] MsrData;
   logic [3:0] Flags;
   logic       CarryIn;
   logic       CondPass;

   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   cpsr_flag_unit dut (
      .CLK(CLK),
      .nReset(nReset),
      .En(En),
      .CondIn(CondIn),
      .OpCode(OpCode),
      .SetFlags(SetFlags),
      .NFlagIn(NFlagIn),
      .ZFlagIn(ZFlagIn),
      .CFlagIn(CFlagIn),
      .VFlagIn(VFlagIn),
      .ShifterCarry(ShifterCarry),
      .MsrWrite(MsrWrite),
      .MsrData(MsrData),
      .Flags(Flags),
      .CarryIn(CarryIn),
      .CondPass(CondPass)
   );

   task automatic check(input string tag, input logic [3:0] obs,
                        input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic probe(input string tag, input logic [3:0] c,
                        input logic exp);
      CondIn = c;
      #1;
      check(tag, {3'b000, CondPass}, {3'b000, exp});
   endtask

   task automatic alu(input logic [3:0] nzcv);
      {NFlagIn, ZFlagIn, CFlagIn, VFlagIn} = nzcv;
   endtask

   task automatic msr_load(input logic [3:0] d);
      En = 1'b1;
      MsrWrite = 1'b1;
      MsrData = d;
      CondIn = 4'b1110;
      step();
      MsrWrite = 1'b0;
   endtask

   // Odd codes below 1110 are the complement of the preceding even code.
   function automatic logic cond_ref(input logic [3:0] f,
                                     input logic [3:0] c);
      logic n, z, cy, v, base;
      {n, z, cy, v} = f;
      base = 1'b1;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy & ~z;
         3'd5: base = ~(n ^ v);
         3'd6: base = ~z & ~(n ^ v);
         default: return 1'b1;
      endcase
      return c[0] ? ~base : base;
   endfunction

   initial begin
      nReset = 1'b0;
      En = 1'b1;
      CondIn = 4'b1110;
      OpCode = 4'b0000;
      SetFlags = 1'b1;
      alu(4'b1111);
      ShifterCarry = 1'b1;
      MsrWrite = 1'b1;
      MsrData = 4'b1111;
      step();
      check("reset_flags", Flags, 4'b0000);
      check("reset_carry", {3'b000, CarryIn}, 4'b0000);
      probe("reset_ne", 4'b0001, 1'b1);
      probe("reset_eq", 4'b0000, 1'b0);
      probe("reset_ge", 4'b1010, 1'b1);
      probe("reset_al", 4'b1110, 1'b1);

      nReset = 1'b1;
      MsrWrite = 1'b0;
      SetFlags = 1'b0;
      OpCode = 4'b1010;
      alu(4'b0110);
      ShifterCarry = 1'b0;
      CondIn = 4'b1110;
      En = 1'b1;
      step();
      check("cmp_flags", Flags, 4'b0110);
      check("cmp_carry", {3'b000, CarryIn}, 4'b0001);
      En = 1'b0;
      probe("beq_pass", 4'b0000, 1'b1);
      probe("hi_fail", 4'b1000, 1'b0);

      msr_load(4'b0011);
      check("msr_0011", Flags, 4'b0011);
      OpCode = 4'b1101;
      SetFlags = 1'b1;
      alu(4'b1000);
      ShifterCarry = 1'b0;
      CondIn = 4'b1110;
      En = 1'b1;
      step();
      check("logic_s", Flags, 4'b1001);
      check("logic_s_carry", {3'b000, CarryIn}, 4'b0000);

      msr_load(4'b0010);
      OpCode = 4'b0101;
      SetFlags = 1'b1;
      alu(4'b0000);
      CondIn = 4'b1110;
      #1;
      check("carry_pre", {3'b000, CarryIn}, 4'b0001);
      step();
      check("carry_post", {3'b000, CarryIn}, 4'b0000);

      msr_load(4'b0100);
      OpCode = 4'b0100;
      SetFlags = 1'b1;
      alu(4'b1111);
      En = 1'b1;
      probe("addne_condpass", 4'b0001, 1'b0);
      step();
      check("addne_hold", Flags, 4'b0100);
      En = 1'b0;
      CondIn = 4'b1110;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_flags", Flags, 4'b0100);
         check("stall_condpass", {3'b000, CondPass}, 4'b0001);
      end

      En = 1'b1;
      OpCode = 4'b1010;
      SetFlags = 1'b0;
      alu(4'b0000);
      CondIn = 4'b0001;
      step();
      check("cmpne_hold", Flags, 4'b0100);

      msr_load(4'b0101);
      OpCode = 4'b1000;
      SetFlags = 1'b0;
      alu(4'b1000);
      ShifterCarry = 1'b1;
      CondIn = 4'b1110;
      step();
      check("tst_implied", Flags, 4'b1011);

      OpCode = 4'b0100;
      SetFlags = 1'b0;
      alu(4'b0100);
      step();
      check("add_no_s", Flags, 4'b1011);

      MsrWrite = 1'b1;
      MsrData = 4'b1001;
      SetFlags = 1'b1;
      alu(4'b0110);
      CondIn = 4'b1110;
      step();
      MsrWrite = 1'b0;
      check("msr_priority", Flags, 4'b1001);
      En = 1'b0;
      probe("msr_ge", 4'b1010, 1'b1);
      probe("msr_gt", 4'b1100, 1'b1);
      probe("msr_lt", 4'b1011, 1'b0);

      En = 1'b1;
      MsrWrite = 1'b1;
      MsrData = 4'b0000;
      CondIn = 4'b0000;
      step();
      MsrWrite = 1'b0;
      check("msr_condfail", Flags, 4'b1001);

      nReset = 1'b0;
      OpCode = 4'b0100;
      SetFlags = 1'b1;
      alu(4'b1111);
      CondIn = 4'b1110;
      step();
      check("reset_midstream", Flags, 4'b0000);
      nReset = 1'b1;
      SetFlags = 1'b0;

      for (int f = 0; f < 16; f++) begin
         msr_load(f[3:0]);
         check("sweep_load", Flags, f[3:0]);
         En = 1'b0;
         for (int c = 0; c < 16; c++) begin
            probe("sweep_cond", c[3:0], cond_ref(f[3:0], c[3:0]));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
